// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined saturating ALU with tag pass-through and committed flags
module alu_pipe #(
   parameter int WIDTH = 16,
   parameter int LANE  = 8,
   parameter int TAGW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src0,
   input  logic [WIDTH-1:0] src1,
   input  logic [TAGW-1:0]  tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAGW-1:0]  out_tag,
   output logic [2:0]       out_flags,
   output logic [2:0]       flags
);
   localparam int SHW   = $clog2(WIDTH);
   localparam int NLANE = WIDTH / LANE;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_PADDSB = 3'b001,
      OP_SUB    = 3'b010,
      OP_AND    = 3'b011,
      OP_NOR    = 3'b100,
      OP_SLL    = 3'b101,
      OP_SRL    = 3'b110,
      OP_SRA    = 3'b111
   } op_t;

   generate
      if ((WIDTH % LANE) != 0 || WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_param
         $error("alu_pipe: WIDTH must be a power of two >= 8 and divisible by LANE");
      end
   endgenerate

   logic             s1_valid;
   op_t              s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [TAGW-1:0]  s1_tag;
   logic             s2_valid;
   op_t              s2_op;
   logic             s2_free;
   logic             s1_adv;
   logic             out_hs;
   logic [WIDTH:0]   add_ext;
   logic [WIDTH:0]   sub_ext;
   logic [WIDTH-1:0] padd_res;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] calc_res;
   logic [2:0]       calc_flags;

   // Sign-extended sum: top two bits disagree exactly when the result overflowed.
   function automatic logic [WIDTH-1:0] sat_full(input logic [WIDTH:0] s);
      if (s[WIDTH] == s[WIDTH-1]) return s[WIDTH-1:0];
      else if (s[WIDTH])          return {1'b1, {(WIDTH-1){1'b0}}};
      else                        return {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   assign add_ext = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
   assign sub_ext = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};
   assign shamt   = s1_b[SHW-1:0];

   for (genvar i = 0; i < NLANE; i++) begin : g_lane
      logic [LANE-1:0] la;
      logic [LANE-1:0] lb;
      logic [LANE:0]   ls;
      assign la = s1_a[i*LANE +: LANE];
      assign lb = s1_b[i*LANE +: LANE];
      assign ls = {la[LANE-1], la} + {lb[LANE-1], lb};
      assign padd_res[i*LANE +: LANE] = (ls[LANE] == ls[LANE-1]) ? ls[LANE-1:0] :
                                        (ls[LANE] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}});
   end

   always_comb begin
      calc_res   = '0;
      calc_flags = 3'b000;
      case (s1_op)
         OP_ADD: begin
            calc_res   = sat_full(add_ext);
            calc_flags = {calc_res[WIDTH-1], add_ext[WIDTH] != add_ext[WIDTH-1], calc_res == '0};
         end
         OP_SUB: begin
            calc_res   = sat_full(sub_ext);
            calc_flags = {calc_res[WIDTH-1], sub_ext[WIDTH] != sub_ext[WIDTH-1], calc_res == '0};
         end
         OP_PADDSB: calc_res = padd_res;
         OP_AND: begin
            calc_res   = s1_a & s1_b;
            calc_flags = {2'b00, calc_res == '0};
         end
         OP_NOR: begin
            calc_res   = ~(s1_a | s1_b);
            calc_flags = {2'b00, calc_res == '0};
         end
         OP_SLL: begin
            calc_res   = s1_a << shamt;
            calc_flags = {2'b00, calc_res == '0};
         end
         OP_SRL: begin
            calc_res   = s1_a >> shamt;
            calc_flags = {2'b00, calc_res == '0};
         end
         OP_SRA: begin
            calc_res   = $unsigned($signed(s1_a) >>> shamt);
            calc_flags = {2'b00, calc_res == '0};
         end
         default: begin
            calc_res   = '0;
            calc_flags = 3'b000;
         end
      endcase
   end

   assign s2_free   = !s2_valid || out_ready;
   assign s1_adv    = s1_valid && s2_free;
   assign in_ready  = !s1_valid || s2_free;
   assign out_valid = s2_valid;
   assign out_hs    = s2_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_tag   <= '0;
      end else begin
         if (in_valid && in_ready) begin
            s1_op  <= op_t'(op);
            s1_a   <= src0;
            s1_b   <= src1;
            s1_tag <= tag;
         end
         if (flush)                      s1_valid <= 1'b0;
         else if (in_valid && in_ready)  s1_valid <= 1'b1;
         else if (s1_adv)                s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_op     <= OP_ADD;
         result    <= '0;
         out_tag   <= '0;
         out_flags <= 3'b000;
         flags     <= 3'b000;
      end else begin
         if (s1_adv) begin
            result    <= calc_res;
            out_tag   <= s1_tag;
            out_flags <= calc_flags;
            s2_op     <= s1_op;
         end
         if (flush)       s2_valid <= 1'b0;
         else if (s1_adv) s2_valid <= 1'b1;
         else if (out_hs) s2_valid <= 1'b0;
         // Arithmetic ops own all three flags; logic/shift ops only refresh zr.
         if (out_hs && !flush) begin
            case (s2_op)
               OP_ADD, OP_SUB: flags    <= out_flags;
               OP_PADDSB:      flags    <= flags;
               default:        flags[0] <= out_flags[0];
            endcase
         end
      end
   end
endmodule
